// File: rtl/bus_interconnect.sv
// rtl/bus_interconnect.sv - shared-bus interconnect: 2 initiators, 2 targets, 1 split target.
// Optional response watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_interconnect #(
    parameter logic [15:0] T1_BASE        = 16'h0000,
    parameter logic [15:0] T2_BASE        = 16'h4000,
    parameter logic [15:0] T3_BASE        = 16'h8000,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init1_req,
    input  logic [15:0] init1_addr_out,
    input  logic        init1_addr_out_valid,
    input  logic [7:0]  init1_data_out,
    input  logic        init1_data_out_valid,
    input  logic        init1_rw,
    input  logic        init1_ready,
    output logic        init1_grant,
    output logic        init1_ack,
    output logic        init1_split_ack,
    output logic [7:0]  init1_data_in,
    output logic        init1_data_in_valid,
    input  logic        init2_req,
    input  logic [15:0] init2_addr_out,
    input  logic        init2_addr_out_valid,
    input  logic [7:0]  init2_data_out,
    input  logic        init2_data_out_valid,
    input  logic        init2_rw,
    input  logic        init2_ready,
    output logic        init2_grant,
    output logic        init2_ack,
    output logic        init2_split_ack,
    output logic [7:0]  init2_data_in,
    output logic        init2_data_in_valid,
    input  logic        target1_ready,
    input  logic        target1_ack,
    input  logic [7:0]  target1_data_out,
    input  logic        target1_data_out_valid,
    output logic [15:0] target1_addr_in,
    output logic        target1_addr_in_valid,
    output logic [7:0]  target1_data_in,
    output logic        target1_data_in_valid,
    output logic        target1_rw,
    input  logic        target2_ready,
    input  logic        target2_ack,
    input  logic [7:0]  target2_data_out,
    input  logic        target2_data_out_valid,
    output logic [15:0] target2_addr_in,
    output logic        target2_addr_in_valid,
    output logic [7:0]  target2_data_in,
    output logic        target2_data_in_valid,
    output logic        target2_rw,
    input  logic        split_target_ready,
    input  logic        split_target_ack,
    input  logic [7:0]  split_target_data_out,
    input  logic        split_target_data_out_valid,
    input  logic        split_target_split_ack,
    input  logic        split_target_req,
    output logic [15:0] split_target_addr_in,
    output logic        split_target_addr_in_valid,
    output logic [7:0]  split_target_data_in,
    output logic        split_target_data_in_valid,
    output logic        split_target_rw,
    output logic        split_target_grant
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_XFER, S_WAIT_RESP, S_SPLIT_RESP} state_t;
    localparam logic [1:0] SEL_NONE = 2'd0, SEL_T1 = 2'd1, SEL_T2 = 2'd2, SEL_T3 = 2'd3;

    state_t      r_state;
    logic        r_owner, r_rw, r_hold, r_hold_rd, r_split_pending, r_split_owner, r_sgrant;
    logic [1:0]  r_sel, r_grant, r_ack, r_sack, r_dv;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata, r_rdata, r_hold_data, r_din0, r_din1;
    logic [2:0]  r_t_av, r_t_dv, r_t_rw;
    logic [15:0] r_t_addr [0:2];
    logic [7:0]  r_t_data [0:2];

    logic        w_o_addr_v, w_o_rw, w_o_ready, w_t_ready, w_t_ack, w_t_dv, w_split, w_due, w_rd;
    logic [15:0] w_o_addr;
    logic [7:0]  w_o_data, w_t_dout, w_rdata;
    logic [1:0]  w_dec, w_tidx;
    logic        w_unused;

    assign w_o_addr_v = r_owner ? init2_addr_out_valid : init1_addr_out_valid;
    assign w_o_addr   = r_owner ? init2_addr_out : init1_addr_out;
    assign w_o_data   = r_owner ? init2_data_out : init1_data_out;
    assign w_o_rw     = r_owner ? init2_rw : init1_rw;
    assign w_o_ready  = r_owner ? init2_ready : init1_ready;
    assign w_tidx     = r_sel - 2'd1;
    assign w_unused   = ^{init1_data_out_valid, init2_data_out_valid};

    always_comb begin
        w_dec = SEL_NONE;
        if (w_o_addr[15:11] == T1_BASE[15:11])      w_dec = SEL_T1;
        else if (w_o_addr[15:11] == T2_BASE[15:11]) w_dec = SEL_T2;
        else if (w_o_addr[15:12] == T3_BASE[15:12]) w_dec = SEL_T3;
    end

    always_comb begin
        w_t_ready = 1'b0;
        w_t_ack   = 1'b0;
        w_t_dv    = 1'b0;
        w_t_dout  = 8'h00;
        case (r_sel)
            SEL_T1: begin w_t_ready = target1_ready; w_t_ack = target1_ack;
                          w_t_dv = target1_data_out_valid; w_t_dout = target1_data_out; end
            SEL_T2: begin w_t_ready = target2_ready; w_t_ack = target2_ack;
                          w_t_dv = target2_data_out_valid; w_t_dout = target2_data_out; end
            SEL_T3: begin w_t_ready = split_target_ready; w_t_ack = split_target_ack;
                          w_t_dv = split_target_data_out_valid; w_t_dout = split_target_data_out; end
            default: ;
        endcase
    end

    assign w_split = (r_state == S_WAIT_RESP) && !r_hold && (r_sel == SEL_T3) && !r_rw
                     && split_target_split_ack;

    // A response is "due" when it must go to the owner; r_hold parks it while the owner is not ready.
    always_comb begin
        w_due   = 1'b0;
        w_rd    = 1'b0;
        w_rdata = 8'h00;
        if (r_hold) begin
            w_due = 1'b1; w_rd = r_hold_rd; w_rdata = r_hold_data;
        end else begin
            case (r_state)
                S_XFER:       if (r_sel == SEL_NONE) begin w_due = 1'b1; w_rd = !r_rw; end
                S_WAIT_RESP:  if (w_t_ack && !w_split) begin
                                  w_due = 1'b1; w_rd = !r_rw; w_rdata = w_t_dv ? w_t_dout : r_rdata;
                              end
                S_SPLIT_RESP: if (w_t_ack) begin
                                  w_due = 1'b1; w_rd = 1'b1; w_rdata = w_t_dv ? w_t_dout : r_rdata;
                              end
                default: ;
            endcase
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= S_IDLE; r_owner <= 1'b0; r_rw <= 1'b0; r_hold <= 1'b0; r_hold_rd <= 1'b0;
            r_split_pending <= 1'b0; r_split_owner <= 1'b0; r_sgrant <= 1'b0;
            r_sel <= SEL_NONE; r_grant <= '0; r_ack <= '0; r_sack <= '0; r_dv <= '0;
            r_addr <= '0; r_wdata <= '0; r_rdata <= '0; r_hold_data <= '0; r_din0 <= '0; r_din1 <= '0;
            r_t_av <= '0; r_t_dv <= '0; r_t_rw <= '0;
            for (int i = 0; i < 3; i++) begin r_t_addr[i] <= '0; r_t_data[i] <= '0; end
`ifdef BUS_TIMEOUT_EN
            r_tmo <= '0;
`endif
        end else begin
            r_ack <= '0; r_sack <= '0; r_dv <= '0; r_din0 <= '0; r_din1 <= '0;
            r_t_av <= '0; r_t_dv <= '0;
            for (int i = 0; i < 3; i++) begin r_t_addr[i] <= '0; r_t_data[i] <= '0; end
            case (r_state)
                S_IDLE: begin
                    r_hold <= 1'b0;
                    if (r_split_pending && split_target_req) begin
                        r_sgrant <= 1'b1; r_owner <= r_split_owner; r_sel <= SEL_T3;
                        r_t_rw[2] <= 1'b0; r_rdata <= '0; r_state <= S_SPLIT_RESP;
                    end else if (init1_req) begin
                        r_grant <= 2'b01; r_owner <= 1'b0; r_state <= S_ADDR;
                    end else if (init2_req) begin
                        r_grant <= 2'b10; r_owner <= 1'b1; r_state <= S_ADDR;
                    end
                end
                S_ADDR: if (w_o_addr_v) begin
                    r_addr <= w_o_addr; r_rw <= w_o_rw; r_wdata <= w_o_data;
                    r_sel <= w_dec; r_rdata <= '0; r_state <= S_XFER;
                end
                S_XFER: if (r_sel != SEL_NONE && w_t_ready) begin
                    r_t_av[w_tidx] <= 1'b1; r_t_addr[w_tidx] <= r_addr; r_t_rw[w_tidx] <= r_rw;
                    if (r_rw) begin r_t_data[w_tidx] <= r_wdata; r_t_dv[w_tidx] <= 1'b1; end
                    r_state <= S_WAIT_RESP;
                end
                S_WAIT_RESP: begin
                    if (w_t_dv && !r_hold) r_rdata <= w_t_dout;
                    if (w_split) begin
                        r_sack[r_owner] <= 1'b1; r_split_pending <= 1'b1; r_split_owner <= r_owner;
                        r_grant <= '0; r_state <= S_IDLE;
                    end
                end
                S_SPLIT_RESP: if (w_t_dv && !r_hold) r_rdata <= w_t_dout;
                default: r_state <= S_IDLE;
            endcase
            if (w_due) begin
                if (w_o_ready) begin
                    r_ack[r_owner] <= 1'b1; r_dv[r_owner] <= w_rd;
                    if (r_owner) r_din1 <= w_rd ? w_rdata : 8'h00;
                    else         r_din0 <= w_rd ? w_rdata : 8'h00;
                    if (r_state == S_SPLIT_RESP) r_split_pending <= 1'b0;
                    r_grant <= '0; r_sgrant <= 1'b0; r_hold <= 1'b0; r_state <= S_IDLE;
                end else begin
                    r_hold <= 1'b1; r_hold_rd <= w_rd; r_hold_data <= w_rdata;
                    if (r_state == S_XFER) r_state <= S_WAIT_RESP;
                end
            end
`ifdef BUS_TIMEOUT_EN
            if (r_state == S_XFER || r_state == S_WAIT_RESP || r_state == S_SPLIT_RESP) begin
                if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    r_ack[r_owner] <= 1'b1;
                    r_dv[r_owner] <= (r_state == S_SPLIT_RESP) || !r_rw;
                    if (r_owner) r_din1 <= ((r_state == S_SPLIT_RESP) || !r_rw) ? 8'hFF : 8'h00;
                    else         r_din0 <= ((r_state == S_SPLIT_RESP) || !r_rw) ? 8'hFF : 8'h00;
                    if (r_state == S_SPLIT_RESP) r_split_pending <= 1'b0;
                    r_grant <= '0; r_sgrant <= 1'b0; r_hold <= 1'b0; r_state <= S_IDLE; r_tmo <= '0;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end else begin
                r_tmo <= '0;
            end
`endif
        end
    end

    assign init1_grant = r_grant[0];  assign init2_grant = r_grant[1];
    assign init1_ack = r_ack[0];      assign init2_ack = r_ack[1];
    assign init1_split_ack = r_sack[0]; assign init2_split_ack = r_sack[1];
    assign init1_data_in = r_din0;    assign init2_data_in = r_din1;
    assign init1_data_in_valid = r_dv[0]; assign init2_data_in_valid = r_dv[1];
    assign target1_addr_in = r_t_addr[0]; assign target1_addr_in_valid = r_t_av[0];
    assign target1_data_in = r_t_data[0]; assign target1_data_in_valid = r_t_dv[0];
    assign target1_rw = r_t_rw[0];
    assign target2_addr_in = r_t_addr[1]; assign target2_addr_in_valid = r_t_av[1];
    assign target2_data_in = r_t_data[1]; assign target2_data_in_valid = r_t_dv[1];
    assign target2_rw = r_t_rw[1];
    assign split_target_addr_in = r_t_addr[2]; assign split_target_addr_in_valid = r_t_av[2];
    assign split_target_data_in = r_t_data[2]; assign split_target_data_in_valid = r_t_dv[2];
    assign split_target_rw = r_t_rw[2];
    assign split_target_grant = r_sgrant;
endmodule

// File: tb/tb_bus_interconnect.sv
// tb/tb_bus_interconnect.sv - directed bench for bus_interconnect with behavioural target models.
module tb_bus_interconnect;
    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        init1_req, init1_addr_out_valid, init1_data_out_valid, init1_rw, init1_ready;
    logic [15:0] init1_addr_out;
    logic [7:0]  init1_data_out, init1_data_in, init2_data_in;
    logic        init1_grant, init1_ack, init1_split_ack, init1_data_in_valid;
    logic        init2_req, init2_addr_out_valid, init2_data_out_valid, init2_rw, init2_ready;
    logic [15:0] init2_addr_out;
    logic [7:0]  init2_data_out;
    logic        init2_grant, init2_ack, init2_split_ack, init2_data_in_valid;
    logic        target1_ready, target1_ack, target1_data_out_valid;
    logic [7:0]  target1_data_out, target1_data_in;
    logic [15:0] target1_addr_in;
    logic        target1_addr_in_valid, target1_data_in_valid, target1_rw;
    logic        target2_ready, target2_ack, target2_data_out_valid;
    logic [7:0]  target2_data_out, target2_data_in;
    logic [15:0] target2_addr_in;
    logic        target2_addr_in_valid, target2_data_in_valid, target2_rw;
    logic        split_target_ready, split_target_ack, split_target_data_out_valid;
    logic        split_target_split_ack, split_target_req;
    logic [7:0]  split_target_data_out, split_target_data_in;
    logic [15:0] split_target_addr_in;
    logic        split_target_addr_in_valid, split_target_data_in_valid, split_target_rw;
    logic        split_target_grant;

    bus_interconnect dut (
        .clk(clk), .rst_n(rst_n),
        .init1_req(init1_req), .init1_addr_out(init1_addr_out), .init1_addr_out_valid(init1_addr_out_valid),
        .init1_data_out(init1_data_out), .init1_data_out_valid(init1_data_out_valid), .init1_rw(init1_rw),
        .init1_ready(init1_ready), .init1_grant(init1_grant), .init1_ack(init1_ack),
        .init1_split_ack(init1_split_ack), .init1_data_in(init1_data_in), .init1_data_in_valid(init1_data_in_valid),
        .init2_req(init2_req), .init2_addr_out(init2_addr_out), .init2_addr_out_valid(init2_addr_out_valid),
        .init2_data_out(init2_data_out), .init2_data_out_valid(init2_data_out_valid), .init2_rw(init2_rw),
        .init2_ready(init2_ready), .init2_grant(init2_grant), .init2_ack(init2_ack),
        .init2_split_ack(init2_split_ack), .init2_data_in(init2_data_in), .init2_data_in_valid(init2_data_in_valid),
        .target1_ready(target1_ready), .target1_ack(target1_ack), .target1_data_out(target1_data_out),
        .target1_data_out_valid(target1_data_out_valid), .target1_addr_in(target1_addr_in),
        .target1_addr_in_valid(target1_addr_in_valid), .target1_data_in(target1_data_in),
        .target1_data_in_valid(target1_data_in_valid), .target1_rw(target1_rw),
        .target2_ready(target2_ready), .target2_ack(target2_ack), .target2_data_out(target2_data_out),
        .target2_data_out_valid(target2_data_out_valid), .target2_addr_in(target2_addr_in),
        .target2_addr_in_valid(target2_addr_in_valid), .target2_data_in(target2_data_in),
        .target2_data_in_valid(target2_data_in_valid), .target2_rw(target2_rw),
        .split_target_ready(split_target_ready), .split_target_ack(split_target_ack),
        .split_target_data_out(split_target_data_out), .split_target_data_out_valid(split_target_data_out_valid),
        .split_target_split_ack(split_target_split_ack), .split_target_req(split_target_req),
        .split_target_addr_in(split_target_addr_in), .split_target_addr_in_valid(split_target_addr_in_valid),
        .split_target_data_in(split_target_data_in), .split_target_data_in_valid(split_target_data_in_valid),
        .split_target_rw(split_target_rw), .split_target_grant(split_target_grant)
    );

    logic [105:0] all_out;
    assign all_out = {init1_grant, init1_ack, init1_split_ack, init1_data_in, init1_data_in_valid,
                      init2_grant, init2_ack, init2_split_ack, init2_data_in, init2_data_in_valid,
                      target1_addr_in, target1_addr_in_valid, target1_data_in, target1_data_in_valid, target1_rw,
                      target2_addr_in, target2_addr_in_valid, target2_data_in, target2_data_in_valid, target2_rw,
                      split_target_addr_in, split_target_addr_in_valid, split_target_data_in,
                      split_target_data_in_valid, split_target_rw, split_target_grant};

    int errors = 0, checks = 0, cyc = 0;
    int t1_lat = 1, t2_lat = 1, s_lat = 4;
    int t1_strobes = 0, t2_strobes = 0, s_strobes = 0, s_wacks = 0, s_racks = 0, i2_dv = 0;
    logic [7:0] mem1 [256], mem2 [256], mems [256];
    logic [7:0] rd1, rd2;
    int ndv1, ndv2, ns1, ns2, g1, g2, a1, a2;

    always @(posedge clk) cyc++;
    initial forever begin @(negedge clk); if (init2_data_in_valid) i2_dv++; end

    initial begin
        int cnt; logic wr; logic [7:0] ad;
        cnt = 0; wr = 0; ad = 0;
        target1_ready = 1; target1_ack = 0; target1_data_out = 0; target1_data_out_valid = 0;
        forever begin
            @(posedge clk); #1;
            target1_ack = 0; target1_data_out_valid = 0;
            if (rst_n) cnt = 0;
            else if (target1_addr_in_valid) begin
                t1_strobes++; wr = target1_rw; ad = target1_addr_in[7:0]; cnt = t1_lat;
                if (wr) mem1[ad] = target1_data_in;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin target1_ack = 1; if (!wr) begin target1_data_out_valid = 1; target1_data_out = mem1[ad]; end end
            end
        end
    end

    initial begin
        int cnt; logic wr; logic [7:0] ad;
        cnt = 0; wr = 0; ad = 0;
        target2_ready = 1; target2_ack = 0; target2_data_out = 0; target2_data_out_valid = 0;
        forever begin
            @(posedge clk); #1;
            target2_ack = 0; target2_data_out_valid = 0;
            if (rst_n) cnt = 0;
            else if (target2_addr_in_valid) begin
                t2_strobes++; wr = target2_rw; ad = target2_addr_in[7:0]; cnt = t2_lat;
                if (wr) mem2[ad] = target2_data_in;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin target2_ack = 1; if (!wr) begin target2_data_out_valid = 1; target2_data_out = mem2[ad]; end end
            end
        end
    end

    initial begin
        int wcnt, spcnt, lcnt; logic [7:0] rdat;
        wcnt = 0; spcnt = 0; lcnt = 0; rdat = 0; mems[8'h01] = 8'h3C;
        split_target_ready = 1; split_target_ack = 0; split_target_data_out = 0;
        split_target_data_out_valid = 0; split_target_split_ack = 0; split_target_req = 0;
        forever begin
            @(posedge clk); #1;
            split_target_ack = 0; split_target_data_out_valid = 0; split_target_split_ack = 0;
            if (rst_n) begin
                wcnt = 0; spcnt = 0; lcnt = 0; split_target_req = 0; split_target_ready = 1;
            end else if (split_target_addr_in_valid) begin
                s_strobes++;
                if (split_target_rw) begin mems[split_target_addr_in[7:0]] = split_target_data_in; wcnt = 1; end
                else begin rdat = mems[split_target_addr_in[7:0]]; spcnt = 1; split_target_ready = 0; end
            end else if (wcnt > 0) begin
                wcnt = 0; split_target_ack = 1; s_wacks++;
            end else if (spcnt > 0) begin
                spcnt = 0; split_target_split_ack = 1; lcnt = s_lat;
            end else if (lcnt > 0) begin
                lcnt--; if (lcnt == 0) split_target_req = 1;
            end else if (split_target_req && split_target_grant) begin
                split_target_req = 0; split_target_ack = 1; split_target_data_out_valid = 1;
                split_target_data_out = rdat; split_target_ready = 1; s_racks++;
            end
        end
    end

    task automatic drive(input int who, input logic rq, input logic [15:0] a, input logic w, input logic [7:0] d);
        if (who == 1) begin
            init1_req = rq; init1_addr_out = a; init1_addr_out_valid = rq; init1_rw = w;
            init1_data_out = d; init1_data_out_valid = rq & w;
        end else begin
            init2_req = rq; init2_addr_out = a; init2_addr_out_valid = rq; init2_rw = w;
            init2_data_out = d; init2_data_out_valid = rq & w;
        end
    endtask

    task automatic txn(input int who, input logic [15:0] a, input logic w, input logic [7:0] wd,
                       output logic [7:0] rd, output int ndv, output int nsplit, output int gcyc, output int acyc);
        bit done = 0;
        logic g, sa, dv, ak; logic [7:0] di;
        rd = 'x; ndv = 0; nsplit = 0; gcyc = -1; acyc = -1;
        @(posedge clk); #1;
        drive(who, 1'b1, a, w, wd);
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            if (who == 1) begin g = init1_grant; sa = init1_split_ack; dv = init1_data_in_valid; ak = init1_ack; di = init1_data_in; end
            else begin g = init2_grant; sa = init2_split_ack; dv = init2_data_in_valid; ak = init2_ack; di = init2_data_in; end
            if (g && gcyc < 0) gcyc = cyc;
            if (sa) begin nsplit++; drive(who, 1'b0, a, w, wd); end
            if (dv) begin ndv++; rd = di; end
            if (ak) begin acyc = cyc; done = 1; drive(who, 1'b0, a, w, wd); end
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL txn_done: init%0d addr %h got no ack, required ack", who, a);
            drive(who, 1'b0, a, w, wd);
        end
    endtask

    task automatic test_reset();
        drive(1, 1'b0, 16'h0, 1'b0, 8'h0); drive(2, 1'b0, 16'h0, 1'b0, 8'h0);
        init1_ready = 1; init2_ready = 1; rst_n = 1;
        repeat (2) @(negedge clk);
        checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", all_out); end
        rst_n = 0;
        @(negedge clk);
        checks++; if (all_out !== '0) begin errors++; $display("FAIL idle_outputs: got %h required 0", all_out); end
    endtask

    task automatic test_split_rw();
        int t1s = t1_strobes, t2s = t2_strobes, wa = s_wacks, ra = s_racks;
        int sp;
        txn(1, 16'h800A, 1'b1, 8'h6D, rd1, ndv1, ns1, g1, a1);
        sp = ns1;
        txn(1, 16'h800A, 1'b0, 8'h00, rd1, ndv1, ns1, g1, a1);
        sp += ns1;
        checks++; if (s_wacks - wa !== 1) begin errors++; $display("FAIL split_wacks: got %0d required 1", s_wacks - wa); end
        checks++; if (s_racks - ra !== 1) begin errors++; $display("FAIL split_racks: got %0d required 1", s_racks - ra); end
        checks++; if (sp !== 1) begin errors++; $display("FAIL split_ack_count: got %0d required 1", sp); end
        checks++; if (ndv1 !== 1) begin errors++; $display("FAIL split_dv_count: got %0d required 1", ndv1); end
        checks++; if (rd1 !== 8'h6D) begin errors++; $display("FAIL split_rdata: got %h required 6d", rd1); end
        checks++; if ((t1_strobes - t1s) + (t2_strobes - t2s) !== 0) begin
            errors++; $display("FAIL split_other_targets: got %0d strobes required 0", (t1_strobes - t1s) + (t2_strobes - t2s)); end
    endtask

    task automatic test_target1_rw();
        int t1s = t1_strobes, t2s = t2_strobes, ss = s_strobes;
        txn(2, 16'h0005, 1'b1, 8'hA5, rd2, ndv2, ns2, g2, a2);
        checks++; if (t1_strobes - t1s !== 1) begin errors++; $display("FAIL t1_write_strobe: got %0d required 1", t1_strobes - t1s); end
        txn(2, 16'h0005, 1'b0, 8'h00, rd2, ndv2, ns2, g2, a2);
        checks++; if (t1_strobes - t1s !== 2) begin errors++; $display("FAIL t1_read_strobe: got %0d required 2", t1_strobes - t1s); end
        checks++; if (rd2 !== 8'hA5) begin errors++; $display("FAIL t1_rdata: got %h required a5", rd2); end
        checks++; if (ndv2 !== 1) begin errors++; $display("FAIL t1_dv_count: got %0d required 1", ndv2); end
        checks++; if ((t2_strobes - t2s) + (s_strobes - ss) !== 0) begin
            errors++; $display("FAIL t1_other_targets: got %0d required 0", (t2_strobes - t2s) + (s_strobes - ss)); end
    endtask

    task automatic test_ready_hold();
        int rc = 0;
        init1_ready = 0;
        fork
            txn(1, 16'h0005, 1'b0, 8'h00, rd1, ndv1, ns1, g1, a1);
            begin repeat (8) @(posedge clk); #1; init1_ready = 1; rc = cyc; end
        join
        checks++; if (rd1 !== 8'hA5 || ndv1 !== 1) begin errors++; $display("FAIL hold_rdata: got %h x%0d required a5 x1", rd1, ndv1); end
        checks++; if (a1 !== rc + 1) begin errors++; $display("FAIL hold_ack_cycle: got %0d required %0d", a1, rc + 1); end
    endtask

    task automatic test_arbitration();
        fork
            txn(1, 16'h4010, 1'b1, 8'h11, rd1, ndv1, ns1, g1, a1);
            txn(2, 16'h4010, 1'b1, 8'h22, rd2, ndv2, ns2, g2, a2);
        join
        checks++; if (!(g1 < g2)) begin errors++; $display("FAIL arb_order: init1 grant %0d init2 grant %0d required init1 first", g1, g2); end
        checks++; if (g2 !== a1 + 1) begin errors++; $display("FAIL arb_handover: got %0d required %0d", g2, a1 + 1); end
        checks++; if (mem2[8'h10] !== 8'h22) begin errors++; $display("FAIL arb_final_data: got %h required 22", mem2[8'h10]); end
    endtask

    task automatic test_split_concurrent();
        int dv0 = i2_dv, ra = s_racks;
        s_lat = 12;
        fork
            txn(1, 16'h8001, 1'b0, 8'h00, rd1, ndv1, ns1, g1, a1);
            begin repeat (8) @(posedge clk); txn(2, 16'h4001, 1'b1, 8'h5A, rd2, ndv2, ns2, g2, a2); end
        join
        s_lat = 4;
        checks++; if (!(a2 < a1)) begin errors++; $display("FAIL conc_order: init2 ack %0d init1 ack %0d required init2 first", a2, a1); end
        checks++; if (ns1 !== 1 || rd1 !== 8'h3C || ndv1 !== 1) begin
            errors++; $display("FAIL conc_deferred: split %0d data %h x%0d required 1 3c x1", ns1, rd1, ndv1); end
        checks++; if (i2_dv - dv0 !== 0) begin errors++; $display("FAIL conc_init2_dv: got %0d required 0", i2_dv - dv0); end
        checks++; if (mem2[8'h01] !== 8'h5A || s_racks - ra !== 1) begin
            errors++; $display("FAIL conc_write: got %h racks %0d required 5a 1", mem2[8'h01], s_racks - ra); end
    endtask

    task automatic test_unmapped();
        int tot = t1_strobes + t2_strobes + s_strobes;
        txn(1, 16'hC000, 1'b0, 8'h00, rd1, ndv1, ns1, g1, a1);
        checks++; if (ndv1 !== 1 || rd1 !== 8'h00) begin errors++; $display("FAIL unmapped_read: got %h x%0d required 00 x1", rd1, ndv1); end
        txn(1, 16'hC000, 1'b1, 8'h33, rd1, ndv1, ns1, g1, a1);
        checks++; if (a1 !== g1 + 2) begin errors++; $display("FAIL unmapped_write_latency: got %0d required %0d", a1 - g1, 2); end
        checks++; if (ndv1 !== 0) begin errors++; $display("FAIL unmapped_write_dv: got %0d required 0", ndv1); end
        checks++; if (t1_strobes + t2_strobes + s_strobes !== tot) begin
            errors++; $display("FAIL unmapped_strobes: got %0d required 0", t1_strobes + t2_strobes + s_strobes - tot); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        t2_lat = 20;
        @(posedge clk); #1;
        drive(1, 1'b1, 16'h4020, 1'b1, 8'h77);
        for (int n = 0; n < 20 && !seen; n++) begin @(negedge clk); if (target2_addr_in_valid) seen = 1; end
        checks++; if (!seen) begin errors++; $display("FAIL rst_mid_strobe: got none required strobe"); end
        @(negedge clk);
        checks++; if (init1_grant !== 1'b1) begin errors++; $display("FAIL rst_mid_grant: got %b required 1", init1_grant); end
        rst_n = 1; #1;
        checks++; if (all_out !== '0) begin errors++; $display("FAIL rst_mid_outputs: got %h required 0", all_out); end
        drive(1, 1'b0, 16'h0, 1'b0, 8'h0);
        repeat (2) @(negedge clk);
        rst_n = 0; t2_lat = 1;
        txn(1, 16'h4021, 1'b1, 8'h99, rd1, ndv1, ns1, g1, a1);
        txn(1, 16'h4021, 1'b0, 8'h00, rd1, ndv1, ns1, g1, a1);
        checks++; if (rd1 !== 8'h99 || ndv1 !== 1) begin errors++; $display("FAIL rst_after_read: got %h x%0d required 99 x1", rd1, ndv1); end
    endtask

    initial begin
        test_reset();
        test_split_rw();
        test_target1_rw();
        test_ready_hold();
        test_arbitration();
        test_split_concurrent();
        test_unmapped();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_interconnect.md
Name: bus_interconnect

Overview:
- Single-clock parallel shared-bus interconnect for 2 initiators (init1, init2), 2 plain targets (target1, target2) and 1 split-capable target (split_target).
- Arbitrates bus ownership and decodes the 16-bit address to select a target.
- Routes address, data and rw to the selected target, and routes ack and read data back to the owner.
- Tracks one outstanding split read and delivers its deferred response to the originating initiator.

Parameters:
T1_BASE  16'h0000  target1 base; match on addr[15:11] (0x0000-0x07FF)
T2_BASE  16'h4000  target2 base; match on addr[15:11] (0x4000-0x47FF)
T3_BASE  16'h8000  split_target base; match on addr[15:12] (0x8000-0x8FFF)
TIMEOUT_CYCLES  64  response watchdog limit (used only with optional feature)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset; asynchronous, active-high (1 = reset) despite the name
initN_req  in  1  (N=1,2) bus request; held until transaction ends or split_ack received
initN_addr_out, initN_addr_out_valid  in  16,1  address plus qualifier
initN_data_out, initN_data_out_valid  in  8,1  write data plus qualifier
initN_rw  in  1  1=write, 0=read
initN_ready  in  1  initiator can accept response
initN_grant  out  1  bus ownership
initN_ack  out  1  transaction complete pulse
initN_split_ack  out  1  read deferred pulse
initN_data_in, initN_data_in_valid  out  8,1  read data plus qualifier
targetM_ready, targetM_ack  in  1,1  (M=1,2; split_target_* identical) target idle / completion pulse
targetM_data_out, targetM_data_out_valid  in  8,1  read data
targetM_addr_in, targetM_addr_in_valid  out  16,1  forwarded address
targetM_data_in, targetM_data_in_valid  out  8,1  forwarded write data
targetM_rw  out  1  forwarded direction
split_target_split_ack  in  1  target defers current read
split_target_req  in  1  deferred read data ready; requests bus
split_target_grant  out  1  bus granted to split target for response

Behaviour:
- Reset: all outputs 0, state IDLE, split_pending=0, split_owner=none.
- FSM states: IDLE, ADDR, XFER, WAIT_RESP, SPLIT_RESP.
- IDLE arbitration, fixed priority: split_target_req, then init1, then init2.
  - split_target_req is honoured only when split_pending=1.
  - Grant is registered and asserted the cycle after request is seen.
  - Non-preemptive: the grant is held until the transaction ends.
- ADDR state:
  - Latch owner address, rw and write data when initN_addr_out_valid=1.
  - Decode: addr[15:11]==T1_BASE[15:11] selects target1; addr[15:11]==T2_BASE[15:11] selects target2; addr[15:12]==T3_BASE[15:12] selects split_target; anything else is unmapped.
- XFER state:
  - Wait for selected targetM_ready=1.
  - Then drive addr_in_valid for exactly 1 cycle, together with addr_in, rw, and (write only) data_in and data_in_valid.
  - Go to WAIT_RESP.
- Unselected targets: addr_in_valid=0 and data_in_valid=0 at all times. Their addr_in and data_in are driven 0.
- targetM_rw: holds its last driven value until the next transaction to that target.
- WAIT_RESP state:
  - Target ack produces initN_ack 1 cycle later (registered) for 1 cycle.
  - Read data: data_out_valid produces initN_data_in_valid and initN_data_in, same registered timing, exactly one pulse.
  - Then drop grant and return to IDLE.
- Split (WAIT_RESP, split_target read, split_target_split_ack=1):
  - Pulse initN_split_ack for 1 cycle.
  - Set split_pending=1 and split_owner=N.
  - Drop grant and return to IDLE; the bus is free for other traffic.
  - The owner deasserts initN_req and waits.
- SPLIT_RESP state (entered on split_target_req win):
  - Assert split_target_grant and hold split_target_rw=0.
  - Forward split_target ack and data to split_owner only.
  - Then clear split_pending, drop grant, return to IDLE.
- Second access to split_target while split_pending=1: stalls in XFER until split_target_ready=1. No error.
- Unmapped address: no target strobed.
  - Write: initN_ack 2 cycles after ADDR.
  - Read: additionally initN_data_in=8'h00 with valid.
- initN_ready=0 when a response is due: bus holds the response and asserts it when ready=1.
- Owner deasserting initN_req mid-transaction: ignored; the transaction completes.
- Reset mid-transaction: immediate return to reset values. Pending split is discarded.

Optional Feature:
BUS_TIMEOUT_EN
- Defined: a counter runs in XFER, WAIT_RESP and SPLIT_RESP. On reaching TIMEOUT_CYCLES:
  - Abort the transaction.
  - Pulse initN_ack; a read also returns data 8'hFF with valid.
  - Clear split_pending if in SPLIT_RESP.
  - Return to IDLE.
- Undefined: no counter; the bus waits indefinitely.

Test Plan:
- init1 writes 8'h6D to 0x800A, then reads 0x800A; split target (read latency 4) defers the read.
  - Exactly 1 write ack and 1 read ack at split_target; 1 split_ack.
  - 1 init1_data_in_valid carrying 8'h6D.
  - target1 and target2 addr_in_valid never asserted.
- init2 writes 8'hA5 to 0x0005, then reads it -> target1 strobed once per transaction; init2 reads 8'hA5; target2 and split_target untouched.
- init1 and init2 request in the same cycle, both to 0x4010 -> init1 granted first; init2 granted the cycle after init1's transaction returns to IDLE.
- init1 split read pending on 0x8001 while init2 writes 0x4001 -> init2 completes during the split; the deferred data goes only to init1; init2 sees no data_in_valid.
- Read of unmapped 0xC000 -> no target strobed; init1_ack plus data_in_valid with 8'h00.
- rst_n=1 asserted in WAIT_RESP -> all outputs 0 the same cycle; a fresh transaction after release completes normally.
